// File: rtl/branch_pkg.sv
// branch_pkg: RV32I branch funct3 encodings, ALU flag positions and the branch condition function.
package branch_pkg;
  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;
  localparam int FLAG_Z  = 0;
  localparam int FLAG_LT = 1;
  localparam int FLAG_C  = 2;
  // funct3[0] inverts the base comparison; funct3[2:1]=01 is reserved and never taken.
  function automatic logic branch_cond(input logic [2:0] funct3, input logic [3:0] flags);
    return funct3[2:1] == 2'b00 ? flags[FLAG_Z] ^ funct3[0] :
           funct3[2:1] == 2'b01 ? 1'b0 :
           funct3[2:1] == 2'b10 ? flags[FLAG_LT] ^ funct3[0] :
                                  ~flags[FLAG_C] ^ funct3[0];
  endfunction
endpackage

// File: rtl/branch_bht.sv
// branch_bht: direct-mapped table of saturating counters with one combinational read and one update port.
module branch_bht #(
  parameter int DEPTH     = 64,
  parameter int CTR_WIDTH = 2,
  parameter int CTR_INIT  = 1,
  parameter int IDX_W     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);
  localparam logic [CTR_WIDTH-1:0] MAX  = '1;
  localparam logic [CTR_WIDTH-1:0] INIT = CTR_INIT[CTR_WIDTH-1:0];
  logic [CTR_WIDTH-1:0] ctr [DEPTH];
  logic [CTR_WIDTH-1:0] cur, nxt;
  assign rd_taken = ctr[rd_idx][CTR_WIDTH-1];
  assign cur = ctr[upd_idx];
  assign nxt = upd_taken ? (cur == MAX ? cur : cur + 1'b1) : (cur == '0 ? cur : cur - 1'b1);
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ctr[i] <= INIT;
    end else if (upd_en) begin
      ctr[upd_idx] <= nxt;
    end
  end
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: resolves EX conditional branches, predicts IF direction from a BHT,
// flags mispredictions with the redirect PC, and counts branch/mispredict events.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int BHT_DEPTH  = 64,
  parameter int CTR_WIDTH  = 2,
  parameter int CTR_INIT   = 1,
  parameter int PERF_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_WIDTH-1:0]   if_pc,
  output logic                  if_pred_taken,
  input  logic                  ex_valid,
  input  logic                  ex_branch,
  input  logic [2:0]            ex_funct3,
  input  logic [3:0]            ex_flags,
  input  logic [PC_WIDTH-1:0]   ex_pc,
  input  logic [PC_WIDTH-1:0]   ex_target,
  input  logic                  ex_pred_taken,
  output logic                  pcsrc,
  output logic                  mispredict,
  output logic [PC_WIDTH-1:0]   redirect_pc,
  output logic [PERF_WIDTH-1:0] branch_count,
  output logic [PERF_WIDTH-1:0] mispredict_count
);
  localparam int IDX_W = $clog2(BHT_DEPTH);
  logic cond, resolve, unused_ok;
  assign cond        = branch_cond(ex_funct3, ex_flags);
  assign resolve     = ex_valid & ex_branch;
  assign pcsrc       = resolve & cond;
  assign mispredict  = resolve & (cond != ex_pred_taken);
  assign redirect_pc = cond ? ex_target : ex_pc + PC_WIDTH'(4);
  // Only the index bits of the fetch PC reach the table; the rest are intentionally dropped.
  assign unused_ok   = ^if_pc;
  branch_bht #(
    .DEPTH(BHT_DEPTH),
    .CTR_WIDTH(CTR_WIDTH),
    .CTR_INIT(CTR_INIT),
    .IDX_W(IDX_W)
  ) u_bht (
    .clk(clk),
    .rst(rst),
    .rd_idx(if_pc[IDX_W+1:2]),
    .rd_taken(if_pred_taken),
    .upd_en(resolve),
    .upd_idx(ex_pc[IDX_W+1:2]),
    .upd_taken(cond)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (resolve) branch_count <= branch_count + 1'b1;
      if (mispredict) mispredict_count <= mispredict_count + 1'b1;
    end
  end
endmodule
